// File: rtl/wb_cmd_master.sv
// Single-outstanding Wishbone classic initiator: one valid/ready command becomes
// one bus cycle, and that cycle yields exactly one response (read data or timeout).
module wb_cmd_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned ADR_W          = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [ADR_W-1:0] cmd_adr,
  input  logic [31:0]      cmd_dat,
  input  logic [3:0]       cmd_sel,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_dat,
  output logic             rsp_err,
  output logic             wb_cyc_o,
  output logic             wb_stb_o,
  output logic             wb_we_o,
  output logic [ADR_W-1:0] wb_adr_o,
  output logic [3:0]       wb_sel_o,
  output logic [31:0]      wb_dat_o,
  input  logic [31:0]      wb_dat_i,
  input  logic             wb_ack_i,
  output logic             busy,
  output logic [15:0]      timeout_cnt
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  // Wait counter value seen during the last strobe cycle before abort.
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t             state_q, state_d;
  logic [15:0]        wait_q, wait_d;
  logic               cyc_q, cyc_d;
  logic               stb_q, stb_d;
  logic               we_q, we_d;
  logic [ADR_W-1:0]   adr_q, adr_d;
  logic [3:0]         sel_q, sel_d;
  logic [31:0]        dat_q, dat_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [31:0]        rsp_dat_q, rsp_dat_d;
  logic               rsp_err_q, rsp_err_d;
  logic [15:0]        tcnt_q, tcnt_d;

  assign cmd_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = stb_q;
  assign wb_we_o     = we_q;
  assign wb_adr_o    = adr_q;
  assign wb_sel_o    = sel_q;
  assign wb_dat_o    = dat_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_dat     = rsp_dat_q;
  assign rsp_err     = rsp_err_q;
  assign timeout_cnt = tcnt_q;

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    adr_d       = adr_q;
    sel_d       = sel_q;
    dat_d       = dat_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    tcnt_d      = tcnt_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          we_d    = cmd_we;
          adr_d   = cmd_adr;
          dat_d   = cmd_dat;
          sel_d   = cmd_sel;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          wait_d  = '0;
          state_d = BUS;
        end
      end

      BUS: begin
        // Ack is checked first so an ack in the final wait cycle still completes cleanly.
        if (wb_ack_i) begin
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          we_d        = 1'b0;
          rsp_dat_d   = we_q ? 32'h0 : wb_dat_i;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else if (wait_q == WAIT_LAST) begin
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          we_d        = 1'b0;
          rsp_dat_d   = 32'h0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          if (tcnt_q != 16'hFFFF) begin
            tcnt_d = tcnt_q + 16'd1;
          end
          state_d     = RESP;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wait_q      <= '0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      sel_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
      tcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      sel_q       <= sel_d;
      dat_q       <= dat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
      tcnt_q      <= tcnt_d;
    end
  end

endmodule

// File: doc/wb_cmd_master.md
Name: wb_cmd_master

Overview:
Single-outstanding Wishbone classic initiator. It turns a valid/ready command stream into single-word bus read/write cycles toward the peripheral register slaves: the keypad/song-status/LCD-control register block and the timers. Each command produces exactly one response, carrying read data or a timeout error. It sits between a local sequencer (LCD/melody controller or test harness) and the shared Wishbone bus.

Parameters:
TIMEOUT_CYCLES, 255, max cycles stb is held without ack before abort (legal 2..65535)
ADR_W, 32, address width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_we  in  1  1=write, 0=read
cmd_adr  in  ADR_W  byte address
cmd_dat  in  32  write data
cmd_sel  in  4  byte selects
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
rsp_dat  out  32  read data (0 for writes and errors)
rsp_err  out  1  1=timeout
wb_cyc_o  out  1  bus cycle
wb_stb_o  out  1  strobe
wb_we_o  out  1  write enable
wb_adr_o  out  ADR_W  address
wb_sel_o  out  4  byte selects
wb_dat_o  out  32  write data
wb_dat_i  in  32  read data
wb_ack_i  in  1  slave acknowledge
busy  out  1  state != IDLE
timeout_cnt  out  16  saturating count of timed-out transactions

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- All outputs registered except cmd_ready and busy, which decode state.
- Reset values: wb_cyc_o/wb_stb_o/wb_we_o=0, wb_adr_o/wb_sel_o/wb_dat_o=0, rsp_valid=0, rsp_dat=0, rsp_err=0, timeout_cnt=0, state=IDLE.
- FSM: IDLE, BUS, RESP.
- IDLE: cmd_ready=1. On accept, latch we/adr/dat/sel onto wb_* outputs, set cyc=stb=1 on the next edge, clear the wait counter, go to BUS. Latency is 1 cycle from accept to stb visible.
- BUS: cyc, stb and all wb_* outputs are held stable. The wait counter increments each cycle without ack.
  - wb_ack_i=1: drop cyc/stb at the next edge. rsp_dat = wb_dat_i for reads, 0 for writes. rsp_err=0, rsp_valid=1, go to RESP.
  - No ack while wait counter == TIMEOUT_CYCLES-1: stb has then been high exactly TIMEOUT_CYCLES cycles. Drop cyc/stb, rsp_err=1, rsp_dat=0, rsp_valid=1, timeout_cnt+1 (saturates at 0xFFFF), go to RESP.
  - Ack and timeout in the same cycle: ack wins, no error.
- RESP: rsp_valid and payload are held until rsp_ready. On handshake, rsp_valid=0 and go to IDLE. cyc/stb stay 0.
  - This guarantees at least 2 idle bus cycles between strobes, required by slaves whose registered ack only clears after stb drops.
- wb_ack_i outside BUS is ignored: no state change, no response.
- wb_we_o is cleared when cyc drops. wb_adr_o/sel/dat keep their last values.
- cmd_valid while not IDLE: not accepted; the command must be held by the producer.
- Reset mid-transaction: at the next edge cyc/stb=0, any pending response is discarded, state=IDLE. No response is issued for the aborted command.
- rsp_ready held high permanently: response occupies exactly one cycle. Back-to-back commands give stb-to-stb spacing of ack latency + 3 cycles minimum.

Test Plan:
- Write 0x00000005 to adr 0x08 (sel 0xF), slave acks 1 cycle after stb -> stb high 2 cycles, we=1, adr=0x08, dat=5. Then rsp_valid=1, rsp_err=0, rsp_dat=0.
- Read adr 0x00, slave returns 0x0000001A with ack -> rsp_dat=0x1A, rsp_err=0. cmd_ready low from accept until rsp handshake.
- TIMEOUT_CYCLES=16, slave never acks -> stb high exactly 16 cycles. Then rsp_err=1, rsp_dat=0, timeout_cnt=1. A second timeout gives timeout_cnt=2.
- rsp_ready held low 10 cycles after ack -> rsp_valid/rsp_dat stable for all 10 cycles. cmd_ready=0 and no new stb until the handshake.
- Assert reset in 3rd BUS cycle of a read -> cyc/stb=0 next edge, rsp_valid never asserts. Next command completes normally.
- Spurious ack pulse in IDLE, plus ack coinciding with the last timeout cycle -> first ignored. Second yields rsp_err=0 with the captured read data.
